// File: rtl/metaballs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : metaballs_pkg
//  Purpose  : Shared constants, palette codes and the initial-position helper
//             for the metaball renderer and its per-ball contribution units.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package metaballs_pkg;

    // Register stages between the pixel inputs and rgb_o / delayed syncs.
    localparam int PIPE_LAT = 3;

    // Field level and packed {r,g,b} output widths.
    localparam int LEVEL_W = 2;
    localparam int RGB_W   = 6;

    typedef enum logic [1:0] {
        PAL_GREY = 2'd0,
        PAL_RED  = 2'd1,
        PAL_BLUE = 2'd2,
        PAL_INV  = 2'd3
    } palette_e;

    // Balls start evenly spread along one axis, inset by the bounce margin.
    function automatic logic [9:0] init_pos(
        input int idx,
        input int radius,
        input int speed,
        input int extent,
        input int num_balls
    );
        int step;
        step = (extent - 2 * radius - 2 * speed) / num_balls;
        return 10'(radius + speed + idx * step);
    endfunction

endpackage
`default_nettype wire

// File: rtl/metaball_contrib.sv
`default_nettype none
// ============================================================================
//  Module   : metaball_contrib
//  Purpose  : One ball: position/direction registers with edge bounce, plus
//             the first two pixel pipeline stages producing this ball's
//             field contribution for the current pixel.
//  Ports    : clk, rst_n      - clock, async active-low reset
//             move            - advance position this cycle (frame tick, not paused)
//             x, y            - pixel coordinate entering stage 1
//             contrib         - 12-bit field contribution, two cycles after x/y
//  Revision : 1.0 - initial release
// ============================================================================
module metaball_contrib
    import metaballs_pkg::*;
#(
    parameter int         RADIUS     = 48,
    parameter int         SPEED      = 2,
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter logic [9:0] INIT_X     = 10'd50,
    parameter logic [9:0] INIT_Y     = 10'd50,
    parameter bit         INIT_Y_NEG = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [11:0] contrib
);

    localparam logic [9:0]  LO   = 10'(RADIUS + SPEED);
    localparam logic [9:0]  X_HI = 10'(H_ACTIVE - 1 - RADIUS - SPEED);
    localparam logic [9:0]  Y_HI = 10'(V_ACTIVE - 1 - RADIUS - SPEED);
    localparam logic [9:0]  STEP = 10'(SPEED);
    localparam logic [9:0]  RAD  = 10'(RADIUS);
    localparam logic [12:0] R2   = 13'(RADIUS * RADIUS);

    // Returns {new_dir_neg, new_pos}. A bounce reverses direction and steps
    // back inward in the same frame so the ball never sits on the margin.
    function automatic logic [10:0] bounce(
        input logic [9:0] pos,
        input logic       neg,
        input logic [9:0] hi
    );
        if (!neg && pos >= hi) begin
            return {1'b1, pos - STEP};
        end else if (neg && pos <= LO) begin
            return {1'b0, pos + STEP};
        end else if (neg) begin
            return {1'b0, pos - STEP} | 11'h400;
        end else begin
            return {1'b0, pos + STEP};
        end
    endfunction

    logic [9:0] r_bx;
    logic [9:0] r_by;
    logic       r_x_neg;
    logic       r_y_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bx    <= INIT_X;
            r_by    <= INIT_Y;
            r_x_neg <= 1'b0;
            r_y_neg <= INIT_Y_NEG;
        end else if (move) begin
            {r_x_neg, r_bx} <= bounce(r_bx, r_x_neg, X_HI);
            {r_y_neg, r_by} <= bounce(r_by, r_y_neg, Y_HI);
        end
    end

    // Stage 1: per-axis distance and the bounding-box test.
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic [5:0] r_adx;
    logic [5:0] r_ady;
    logic       r_near;

    assign w_dx = (x >= r_bx) ? (x - r_bx) : (r_bx - x);
    assign w_dy = (y >= r_by) ? (y - r_by) : (r_by - y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adx  <= '0;
            r_ady  <= '0;
            r_near <= 1'b0;
        end else begin
            r_adx  <= w_dx[5:0];
            r_ady  <= w_dy[5:0];
            r_near <= (w_dx < RAD) && (w_dy < RAD);
        end
    end

    // Stage 2: squared distance; six bits suffice whenever near is set.
    logic [12:0] w_d2;

    assign w_d2 = {7'd0, r_adx} * {7'd0, r_adx} + {7'd0, r_ady} * {7'd0, r_ady};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contrib <= '0;
        end else if (r_near && w_d2 < R2) begin
            contrib <= 12'(R2 - w_d2);
        end else begin
            contrib <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/metaball_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : metaball_renderer
//  Purpose  : Renders NUM_BALLS bouncing balls as a 4-level field with a
//             selectable 2-bit-per-channel palette, aligned with delayed
//             VGA syncs through a fixed 3-cycle pipeline.
//  Ports    : clk, rst_n          - pixel clock, async active-low reset
//             x, y, display       - pixel coordinate and visible-area flag
//             h_sync, v_sync      - syncs from the timing generator
//             pause               - freeze ball motion
//             palette             - colour mapping select
//             rgb_o               - {r[1:0], g[1:0], b[1:0]}
//             h_sync_o, v_sync_o, display_o - inputs delayed 3 cycles
//  Revision : 1.0 - initial release
// ============================================================================
module metaball_renderer
    import metaballs_pkg::*;
#(
    parameter int NUM_BALLS       = 4,
    parameter int RADIUS          = 48,
    parameter int SPEED           = 2,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             display,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic             pause,
    input  logic [1:0]       palette,
    output logic [RGB_W-1:0] rgb_o,
    output logic             h_sync_o,
    output logic             v_sync_o,
    output logic             display_o
);

    localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
    localparam logic [14:0] R2        = 15'(RADIUS * RADIUS);

    // Sync/display delay lines; bit 0 is the newest sample.
    logic [PIPE_LAT-1:0] r_hs_pipe;
    logic [PIPE_LAT-1:0] r_vs_pipe;
    logic [PIPE_LAT-1:0] r_disp_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_pipe   <= {PIPE_LAT{SYNC_IDLE}};
            r_vs_pipe   <= {PIPE_LAT{SYNC_IDLE}};
            r_disp_pipe <= '0;
        end else begin
            r_hs_pipe   <= {r_hs_pipe[PIPE_LAT-2:0], h_sync};
            r_vs_pipe   <= {r_vs_pipe[PIPE_LAT-2:0], v_sync};
            r_disp_pipe <= {r_disp_pipe[PIPE_LAT-2:0], display};
        end
    end

    assign h_sync_o  = r_hs_pipe[PIPE_LAT-1];
    assign v_sync_o  = r_vs_pipe[PIPE_LAT-1];
    assign display_o = r_disp_pipe[PIPE_LAT-1];

    // The first delay stage doubles as the registered v_sync; comparing it
    // with the second stage yields one tick per sync pulse however long the
    // pulse lasts.
    logic w_move;

    assign w_move = (r_vs_pipe[1] == SYNC_IDLE) && (r_vs_pipe[0] != SYNC_IDLE) && !pause;

    logic [11:0] w_contrib [NUM_BALLS];

    for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_balls
        metaball_contrib #(
            .RADIUS     (RADIUS),
            .SPEED      (SPEED),
            .H_ACTIVE   (H_ACTIVE),
            .V_ACTIVE   (V_ACTIVE),
            .INIT_X     (init_pos(gi, RADIUS, SPEED, H_ACTIVE, NUM_BALLS)),
            .INIT_Y     (init_pos(gi, RADIUS, SPEED, V_ACTIVE, NUM_BALLS)),
            .INIT_Y_NEG ((gi % 2) == 1)
        ) u_contrib (
            .clk     (clk),
            .rst_n   (rst_n),
            .move    (w_move),
            .x       (x),
            .y       (y),
            .contrib (w_contrib[gi])
        );
    end

    // Stage 3: field sum, level quantisation and palette mapping.
    logic [14:0]        w_field;
    logic [LEVEL_W-1:0] w_level;
    logic [RGB_W-1:0]   w_rgb;

    always_comb begin
        w_field = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            w_field = w_field + {3'd0, w_contrib[i]};
        end
    end

    always_comb begin
        if (w_field < (R2 >> 2)) begin
            w_level = 2'd0;
        end else if (w_field < (R2 >> 1)) begin
            w_level = 2'd1;
        end else if (w_field < R2) begin
            w_level = 2'd2;
        end else begin
            w_level = 2'd3;
        end
    end

    always_comb begin
        w_rgb = '0;
        case (palette_e'(palette))
            PAL_GREY: w_rgb = {w_level, w_level, w_level};
            PAL_RED:  w_rgb = {w_level, 1'b0, w_level[1], 2'b00};
            PAL_BLUE: w_rgb = {2'b00, 1'b0, w_level[1], w_level};
            PAL_INV:  w_rgb = {~w_level, ~w_level, ~w_level};
            default:  w_rgb = '0;
        endcase
    end

    // Blanking uses the display bit travelling alongside this pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_o <= '0;
        end else if (r_disp_pipe[PIPE_LAT-2]) begin
            rgb_o <= w_rgb;
        end else begin
            rgb_o <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_metaball_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_metaball_renderer
//  Purpose  : Self-checking bench for metaball_renderer (default parameters).
//             A behavioural field model predicts every output cycle; literal
//             pixel expectations pin the model and the ball trajectories.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_metaball_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       display = 1'b0;
    logic       h_sync = 1'b1;
    logic       v_sync = 1'b1;
    logic       pause = 1'b0;
    logic [1:0] palette = 2'd0;
    logic [5:0] rgb_o;
    logic       h_sync_o;
    logic       v_sync_o;
    logic       display_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    metaball_renderer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .display   (display),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .pause     (pause),
        .palette   (palette),
        .rgb_o     (rgb_o),
        .h_sync_o  (h_sync_o),
        .v_sync_o  (v_sync_o),
        .display_o (display_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int mbx [4];
    int mby [4];
    int mdx [4];
    int mdy [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mbx[i] = 50 + i * ((640 - 96 - 4) / 4);
            mby[i] = 50 + i * ((480 - 96 - 4) / 4);
            mdx[i] = 1;
            mdy[i] = (i % 2 == 1) ? -1 : 1;
        end
    endtask

    task automatic step_axis(input int p, input int d, input int mx, output int np, output int nd);
        np = p;
        nd = d;
        if (d > 0 && p >= mx - 48 - 2) begin
            nd = -1;
            np = p - 2;
        end else if (d < 0 && p <= 50) begin
            nd = 1;
            np = p + 2;
        end else begin
            np = p + d * 2;
        end
    endtask

    task automatic model_move();
        int np, nd;
        for (int i = 0; i < 4; i++) begin
            step_axis(mbx[i], mdx[i], 639, np, nd);
            mbx[i] = np;
            mdx[i] = nd;
            step_axis(mby[i], mdy[i], 479, np, nd);
            mby[i] = np;
            mdy[i] = nd;
        end
    endtask

    function automatic logic [1:0] model_level(input int px, input int py);
        int f, adx, ady;
        f = 0;
        for (int i = 0; i < 4; i++) begin
            adx = (px > mbx[i]) ? px - mbx[i] : mbx[i] - px;
            ady = (py > mby[i]) ? py - mby[i] : mby[i] - py;
            if (adx < 48 && ady < 48 && adx * adx + ady * ady < 2304)
                f = f + 2304 - (adx * adx + ady * ady);
        end
        if (f < 576) return 2'd0;
        if (f < 1152) return 2'd1;
        if (f < 2304) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [5:0] pal_map(input logic [1:0] lv, input logic [1:0] p);
        int l, r, g, b;
        l = lv;
        case (p)
            2'd0: begin r = l; g = l; b = l; end
            2'd1: begin r = l; g = l / 2; b = 0; end
            2'd2: begin r = 0; g = l / 2; b = l; end
            default: begin r = 3 - l; g = 3 - l; b = 3 - l; end
        endcase
        return {2'(r), 2'(g), 2'(b)};
    endfunction

    // Level is fixed by the pixel's coordinates; palette and blanking are
    // applied as the pixel enters the last stage.
    logic [1:0] l0, l1;
    logic [2:0] s0, s1;
    logic [8:0] e2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l0 <= 2'd0;
            l1 <= 2'd0;
            s0 <= 3'b110;
            s1 <= 3'b110;
            e2 <= 9'b000000_110;
        end else begin
            l0 <= model_level(int'(x), int'(y));
            s0 <= {h_sync, v_sync, display};
            l1 <= l0;
            s1 <= s0;
            e2 <= {(s1[0] ? pal_map(l1, palette) : 6'd0), s1};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({rgb_o, h_sync_o, v_sync_o, display_o} !== e2) begin
                errors++;
                if (errors < 30)
                    $display("FAIL model_cmp t=%0t got=%b want=%b", $time,
                             {rgb_o, h_sync_o, v_sync_o, display_o}, e2);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic pix(input int px, input int py, input logic disp, input logic [1:0] pal,
                       input logic [5:0] want, input string name);
        @(posedge clk);
        #1;
        x = px[9:0];
        y = py[9:0];
        display = disp;
        palette = pal;
        repeat (3) @(posedge clk);
        #2;
        chk(name, {3'b000, rgb_o}, {3'b000, want});
        display = 1'b0;
    endtask

    task automatic do_tick(input int hold);
        @(posedge clk);
        #1;
        display = 1'b0;
        v_sync = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        v_sync = 1'b1;
        repeat (4) @(posedge clk);
        if (!pause) model_move();
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic scan(input int cx, input int cy);
        for (int d = -52; d <= 52; d++) begin
            @(posedge clk);
            #1;
            x = 10'(clamp(cx + d, 639));
            y = 10'(cy);
            display = ((d + 60) % 7) != 0;
            h_sync = ((d + 60) % 16) >= 3;
            if (((d + 60) % 32) == 0) palette = palette + 2'd1;
        end
        for (int d = -52; d <= 52; d++) begin
            @(posedge clk);
            #1;
            x = 10'(cx);
            y = 10'(clamp(cy + d, 479));
            display = ((d + 60) % 5) != 0;
        end
        @(posedge clk);
        #1;
        display = 1'b0;
        h_sync = 1'b1;
    endtask

    task automatic scan_all();
        for (int i = 0; i < 4; i++) scan(mbx[i], mby[i]);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        model_reset();
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", {rgb_o, h_sync_o, v_sync_o, display_o}, 9'b000000_110);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Initial positions and palette mapping.
        pix(50, 50, 1'b1, 2'd0, 6'b111111, "ball0_centre");
        pix(185, 145, 1'b1, 2'd0, 6'b111111, "ball1_centre");
        pix(320, 240, 1'b1, 2'd0, 6'b111111, "ball2_centre");
        pix(455, 335, 1'b1, 2'd0, 6'b111111, "ball3_centre");
        pix(74, 50, 1'b1, 2'd0, 6'b101010, "level2_at_74_50");
        pix(98, 50, 1'b1, 2'd0, 6'b000000, "outside_at_98_50");
        pix(50, 50, 1'b0, 2'd0, 6'b000000, "blank_centre");
        pix(74, 50, 1'b0, 2'd0, 6'b000000, "blank_74_50");
        pix(98, 50, 1'b1, 2'd3, 6'b111111, "pal_inv_outside");
        pix(50, 50, 1'b1, 2'd1, 6'b110100, "pal_red_centre");
        pix(50, 50, 1'b1, 2'd2, 6'b000111, "pal_blue_centre");
        scan_all();

        // One tick, then one very long sync pulse counting as a single tick.
        palette = 2'd0;
        do_tick(4);
        pix(52, 52, 1'b1, 2'd0, 6'b111111, "tick1_ball0");
        pix(50, 50, 1'b1, 2'd0, 6'b101010, "tick1_old_centre");
        pix(187, 143, 1'b1, 2'd0, 6'b111111, "tick1_ball1");
        do_tick(300);
        pix(54, 54, 1'b1, 2'd0, 6'b111111, "long_pulse_ball0");
        pix(52, 52, 1'b1, 2'd0, 6'b101010, "long_pulse_prev");

        // Pause holds across several ticks; releasing moves exactly one step.
        pause = 1'b1;
        repeat (5) do_tick(3);
        pix(54, 54, 1'b1, 2'd0, 6'b111111, "paused_ball0");
        pause = 1'b0;
        do_tick(3);
        pix(56, 56, 1'b1, 2'd0, 6'b111111, "unpaused_ball0");
        scan_all();

        // Reset in the middle of visible output.
        @(posedge clk);
        #1;
        x = 10'd56;
        y = 10'd56;
        display = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midframe_reset", {rgb_o, h_sync_o, v_sync_o, display_o}, 9'b000000_110);
        model_reset();
        display = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pix(50, 50, 1'b1, 2'd0, 6'b111111, "post_reset_ball0");
        pix(185, 145, 1'b1, 2'd0, 6'b111111, "post_reset_ball1");

        // Long run through the bounces.
        for (int t = 1; t <= 271; t++) begin
            do_tick(2);
            if (t == 48) pix(281, 49, 1'b1, 2'd0, 6'b111111, "ball1_y_at_49");
            if (t == 49) begin
                pix(283, 51, 1'b1, 2'd0, 6'b111111, "ball1_y_flip_51");
                pix(281, 49, 1'b1, 2'd0, 6'b101010, "ball1_prev_pos");
            end
            if (t == 270) pix(590, 270, 1'b1, 2'd0, 6'b111111, "ball0_x_at_590");
            if (t == 271) pix(588, 268, 1'b1, 2'd0, 6'b111111, "ball0_x_flip_588");
        end
        scan_all();

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
